mem_access_unit: RTL

- MEM-stage controller between the EX/MEM pipeline register and a variable-latency data memory (req/ack, word-addressed, byte write enables).
- Aligns store data and write enables, and detects misaligned accesses.
- Stalls the pipeline while an access is outstanding.
- Registers the raw 32-bit read word, address low bits and load type into WB, where the data extension stage consumes them (raw word, byte select, load mode).

---
 rtl/mem_access_unit_pkg.sv | 35 +++
 rtl/mem_access_unit_store_lane_align.sv | 36 +++
 rtl/mem_access_unit.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage access controller: store/load types,
// FSM states and the latched request record.
package mem_access_unit_pkg;

  localparam logic [1:0] SNONE = 2'd0;
  localparam logic [1:0] SB    = 2'd1;
  localparam logic [1:0] SH    = 2'd2;
  localparam logic [1:0] SW    = 2'd3;

  localparam logic [2:0] NOREGWRITE = 3'd0;
  localparam logic [2:0] LB         = 3'd1;
  localparam logic [2:0] LH         = 3'd2;
  localparam logic [2:0] LW         = 3'd3;
  localparam logic [2:0] LBU        = 3'd4;
  localparam logic [2:0] LHU        = 3'd5;

  typedef enum logic {
    MA_IDLE = 1'b0,
    MA_REQ  = 1'b1
  } ma_state_e;

  // Everything captured when a request is launched; held stable in MA_REQ.
  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [1:0]  sel;
    logic [2:0]  ld_type;
  } mem_req_t;

  function automatic logic is_load_type(input logic [2:0] t);
    return (t == LB) || (t == LH) || (t == LW) || (t == LBU) || (t == LHU);
  endfunction

endpackage

// File: rtl/mem_access_unit_store_lane_align.sv
// Places store data and byte enables on the memory lanes selected by the
// low address bits. Purely combinational.
module store_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  store_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [3:0]  we,
  output logic [31:0] wdata
);

  always_comb begin
    we    = 4'b0000;
    wdata = 32'h0;
    case (store_type)
      SB: begin
        we    = 4'b0001 << addr_lo;
        wdata = data << {addr_lo, 3'b000};
      end
      SH: begin
        we    = 4'b0011 << addr_lo;
        wdata = data << {addr_lo, 3'b000};
      end
      SW: begin
        we    = 4'b1111;
        wdata = data;
      end
      default: begin
        we    = 4'b0000;
        wdata = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage controller: launches aligned loads/stores to a req/ack data
// memory, stalls while outstanding, and registers the result into WB.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int MAX_WAIT = 64
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        AccValidM,
  input  logic [31:0] AddrM,
  input  logic [31:0] StoreDataM,
  input  logic [1:0]  StoreTypeM,
  input  logic [2:0]  LoadTypeM,
  output logic        MemReq,
  output logic [3:0]  MemWe,
  output logic [29:0] MemAddr,
  output logic [31:0] MemWData,
  input  logic        MemAck,
  input  logic [31:0] MemRData,
  output logic [31:0] RawWordW,
  output logic [1:0]  LoadedBytesSelectW,
  output logic [2:0]  LoadTypeW,
  output logic        MemStall,
  output logic        MisalignErr,
  output logic        BusErr
);

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  ma_state_e   state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  mem_req_t    req_q, req_d;
  logic [31:0] raw_d;
  logic [1:0]  sel_d;
  logic [2:0]  ldw_d;
  logic        mis_d, bus_d;

  logic        is_store, is_load, access, is_half, is_word, misaligned, start;
  logic [3:0]  lane_we;
  logic [31:0] lane_wdata;

  store_lane_align u_align (
    .store_type (StoreTypeM),
    .addr_lo    (AddrM[1:0]),
    .data       (StoreDataM),
    .we         (lane_we),
    .wdata      (lane_wdata)
  );

  // A store wins if the decoder ever flags both a store and a load.
  assign is_store   = (StoreTypeM != SNONE);
  assign is_load    = !is_store && is_load_type(LoadTypeM);
  assign access     = AccValidM && (is_store || is_load);
  assign is_half    = is_store ? (StoreTypeM == SH) : ((LoadTypeM == LH) || (LoadTypeM == LHU));
  assign is_word    = is_store ? (StoreTypeM == SW) : (LoadTypeM == LW);
  assign misaligned = access && ((is_half && AddrM[0]) || (is_word && (AddrM[1:0] != 2'b00)));
  assign start      = access && !misaligned;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    raw_d    = RawWordW;
    sel_d    = LoadedBytesSelectW;
    ldw_d    = NOREGWRITE;
    mis_d    = 1'b0;
    bus_d    = 1'b0;
    MemStall = 1'b0;
    case (state_q)
      MA_IDLE: begin
        mis_d = misaligned;
        if (start) begin
          MemStall      = 1'b1;
          state_d       = MA_REQ;
          cnt_d         = 8'd0;
          req_d.addr    = AddrM[31:2];
          req_d.we      = lane_we;
          req_d.wdata   = lane_wdata;
          req_d.sel     = AddrM[1:0];
          req_d.ld_type = is_store ? NOREGWRITE : LoadTypeM;
        end
      end
      MA_REQ: begin
        if (MemAck) begin
          state_d = MA_IDLE;
          if (req_q.ld_type != NOREGWRITE) raw_d = MemRData;
          sel_d   = req_q.sel;
          ldw_d   = req_q.ld_type;
        end else if (cnt_q == WAIT_LAST) begin
          // Abort releases the stall so the faulting access leaves MEM.
          state_d = MA_IDLE;
          bus_d   = 1'b1;
        end else begin
          MemStall = 1'b1;
          cnt_d    = cnt_q + 8'd1;
        end
      end
      default: state_d = MA_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q            <= MA_IDLE;
      cnt_q              <= 8'd0;
      req_q              <= '0;
      RawWordW           <= 32'h0;
      LoadedBytesSelectW <= 2'd0;
      LoadTypeW          <= NOREGWRITE;
      MisalignErr        <= 1'b0;
      BusErr             <= 1'b0;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      req_q              <= req_d;
      RawWordW           <= raw_d;
      LoadedBytesSelectW <= sel_d;
      LoadTypeW          <= ldw_d;
      MisalignErr        <= mis_d;
      BusErr             <= bus_d;
    end
  end

  assign MemReq   = (state_q == MA_REQ);
  assign MemWe    = req_q.we;
  assign MemAddr  = req_q.addr;
  assign MemWData = req_q.wdata;

endmodule
